// File: rtl/i2s_pkg.sv
// Shared defaults and types for the I2S transmit path.
package i2s_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_SLOT_W = 32;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] l;
    logic [DEF_DATA_W-1:0] r;
  } stereo_sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV enabled clk cycles and
// strobes fall_tick in the cycle whose closing edge takes bclk from 1 to 0.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bclk,
  output logic fall_tick
);

  localparam int DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DivW-1:0] divCnt;
  logic            wrap;

  assign wrap      = (divCnt == DivW'(BCLK_DIV - 1));
  assign fall_tick = enable & wrap & bclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
      bclk   <= 1'b0;
    end else if (enable) begin
      if (wrap) begin
        divCnt <= '0;
        bclk   <= ~bclk;
      end else begin
        divCnt <= divCnt + DivW'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one-entry stereo buffer, frame sequencer and serial data path.
//   state | meaning
//   IDLE  | bit/word clocks held, waiting for the first sample
//   RUN   | bclk/lrclk free-running until reset; empty buffer at frame start sends zeros
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam int FrameBits = 2 * SLOT_W;
  localparam int BitW      = $clog2(FrameBits);

  tx_state_t       state, stateNext;
  stereo_sample_t  bufReg, frameReg;
  logic            bufFull;
  logic [BitW-1:0] bitCnt, bitCntNext, slotPos;
  logic [DATA_W-1:0] chanWord, chanShift;
  logic            runEn, fallTick, accept, load, lrclkNext, sdataNext;

  assign runEn = (state == RUN);

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) uBclkGen (
    .clk       (clk),
    .reset     (reset),
    .enable    (runEn),
    .bclk      (bclk),
    .fall_tick (fallTick)
  );

  assign sample_ready = ~bufFull;
  assign accept       = sample_valid & ~bufFull;

  always_comb begin
    stateNext = state;
    if (state == IDLE && accept) stateNext = RUN;
  end

  // Everything below describes the values taken on the next bclk fall.
  always_comb begin
    bitCntNext = (bitCnt == BitW'(FrameBits - 1)) ? '0 : bitCnt + BitW'(1);
    load       = fallTick && (bitCntNext == '0);
    lrclkNext  = (bitCntNext >= BitW'(SLOT_W));
    slotPos    = lrclkNext ? bitCntNext - BitW'(SLOT_W) : bitCntNext;
    chanWord   = lrclkNext ? frameReg.r : frameReg.l;
    chanShift  = chanWord << (slotPos - BitW'(1));
    sdataNext  = 1'b0;
    if (slotPos != '0 && slotPos <= BitW'(DATA_W)) sdataNext = chanShift[DATA_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitCnt   <= BitW'(FrameBits - 1);
      lrclk    <= 1'b1;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      bufFull  <= 1'b0;
      bufReg   <= '0;
      frameReg <= '0;
    end else begin
      state    <= stateNext;
      underrun <= load & ~bufFull;
      if (fallTick) begin
        bitCnt <= bitCntNext;
        lrclk  <= lrclkNext;
        sdata  <= sdataNext;
      end
      if (load) frameReg <= bufFull ? bufReg : '0;
      // A same-cycle accept lands after the load, so it waits for the next frame.
      if (accept) begin
        bufReg.l <= sample_l;
        bufReg.r <= sample_r;
        bufFull  <= 1'b1;
      end else if (load) begin
        bufFull  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: directed steps plus random offers, checked against a frame-level model.
module tb_i2s_tx_serializer;

  localparam int DW        = 16;
  localparam int SW        = 32;
  localparam int DIV       = 2;
  localparam int FRAME_CLK = 2 * DIV * 2 * SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_l, sample_r;
  logic          sample_valid;
  logic          sample_ready, bclk, lrclk, sdata, underrun;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: buffer occupancy, frame in flight, timing anchors.
  bit            running, haveBuf, lastAcc, expUnder;
  logic [DW-1:0] bufL, bufR, curL, curR;
  int            edgeNo, startEdge, nextLoad, curLoad, pair;

  i2s_tx_serializer #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, expv, edgeNo);
    end
  endtask

  // One clk cycle: advance the model across the edge, then compare at +1.
  task automatic tick();
    bit            acc;
    logic [DW-1:0] inL, inR, w;
    logic          expBit;
    int            rel, m, b, i, p;
    acc = sample_valid && !haveBuf;
    inL = sample_l;
    inR = sample_r;
    @(posedge clk);
    edgeNo++;
    expUnder = 1'b0;
    if (running && edgeNo == nextLoad) begin
      expUnder = !haveBuf;
      curL     = haveBuf ? bufL : '0;
      curR     = haveBuf ? bufR : '0;
      haveBuf  = 1'b0;
      curLoad  = nextLoad;
      nextLoad = nextLoad + FRAME_CLK;
    end
    lastAcc = acc;
    if (acc) begin
      bufL    = inL;
      bufR    = inR;
      haveBuf = 1'b1;
      if (!running) begin
        running   = 1'b1;
        startEdge = edgeNo;
        nextLoad  = edgeNo + 2 * DIV;
      end
    end
    #1;
    chk("ready", sample_ready, !haveBuf);
    chk("underrun", underrun, expUnder);
    rel = edgeNo - startEdge;
    chk("bclk", bclk, running ? (rel / DIV) % 2 : 0);
    if (running && rel % (2 * DIV) == DIV) begin
      m = rel / (2 * DIV);
      if (m == 0) begin
        chk("lr_prefirst", lrclk, 1);
        chk("sd_prefirst", sdata, 0);
      end else begin
        b      = (m - 1) % (2 * SW);
        i      = b / SW;
        p      = b % SW;
        w      = (i == 1) ? curR : curL;
        expBit = (p >= 1 && p <= DW) ? w[4'(DW - p)] : 1'b0;
        chk("lrclk", lrclk, i);
        chk("sdata", sdata, expBit);
      end
    end
  endtask

  // Called at +1 after an edge; asserts reset mid-cycle and checks values before the next edge.
  task automatic doReset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 1);
    chk("rst_sdata", sdata, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_underrun", underrun, 0);
    running      = 1'b0;
    haveBuf      = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    edgeNo = edgeNo + 3;
    #1;
    reset = 1'b0;
  endtask

  task automatic startWithStep2Timing();
    sample_l     = 16'h7FFF;
    sample_r     = 16'h8000;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    chk("lr_before_fall", lrclk, 1);
    tick();
    chk("lr_fall_at_n4", lrclk, 0);
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    running      = 1'b0;
    haveBuf      = 1'b0;
    edgeNo       = 0;
    startEdge    = 0;
    nextLoad     = 0;
    curLoad      = 0;
    curL         = '0;
    curR         = '0;
    pair         = 0;

    // 1: async reset, then idle without offers
    @(posedge clk);
    #1;
    doReset();
    repeat (200) tick();

    // 2: first sample, latency and slot content
    startWithStep2Timing();

    // 3: alternating pairs offered continuously
    sample_l     = 16'h7FFF;
    sample_r     = 16'h8000;
    sample_valid = 1'b1;
    for (int c = 0; c < 4 * FRAME_CLK; c++) begin
      tick();
      if (lastAcc) begin
        pair++;
        sample_l = pair[0] ? 16'h8000 : 16'h7FFF;
        sample_r = pair[0] ? 16'h7FFF : 16'h8000;
      end
    end

    // 4: stop offering; the frame after the drained buffer underruns
    sample_valid = 1'b0;
    repeat (2 * FRAME_CLK + 20) tick();

    // 5: offer exactly on a load edge with the buffer empty
    for (int c = 0; c < FRAME_CLK + 4 && edgeNo + 1 != nextLoad; c++) tick();
    sample_l     = 16'($urandom);
    sample_r     = 16'($urandom);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (2 * FRAME_CLK + 20) tick();

    // random offers and mid-frame input noise
    for (int c = 0; c < 20 * FRAME_CLK; c++) begin
      if (!sample_valid) begin
        sample_l = 16'($urandom);
        sample_r = 16'($urandom);
        if ($urandom_range(0, 199) == 0) sample_valid = 1'b1;
      end
      tick();
      if (lastAcc) sample_valid = 1'b0;
    end
    sample_valid = 1'b0;

    // 6: reset at bit_cnt=20 of a running frame, then restart
    for (int c = 0; c < 2 * FRAME_CLK && edgeNo != curLoad + 80; c++) tick();
    doReset();
    repeat (50) tick();
    startWithStep2Timing();
    repeat (FRAME_CLK + 20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
